// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing D = A - B one bit per clock, LSB first,
//   with a single full-subtractor cell and a borrow register. Operands are
//   accepted through a start/busy/done handshake. Results are loaded only
//   when the last bit is produced and hold until the next completion.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; sampled only while busy = 0
//   A      in   minuend, captured on the accepting edge
//   B      in   subtrahend, captured on the accepting edge
//   busy   out  high while the serial computation runs
//   done   out  one-cycle pulse; D/Bout/ovf valid
//   D      out  A - B mod 2^WIDTH
//   Bout   out  final borrow (1 iff A < B unsigned)
//   ovf    out  signed overflow flag
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Holds the WIDTH-1 most recently produced bits; the final bit joins them
  // on the completing edge so D is loaded in the same cycle it is finished.
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full-subtractor cell
  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_br;
  assign w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  // New bit enters from the MSB side; after WIDTH shifts bit 0 is the LSB.
  assign w_res_next = {w_d, r_res};
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next[WIDTH-1:1];
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_d     <= w_res_next;
            r_bout  <= w_br_next;
            // w_d is the result MSB on the final bit
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation (busy = 0 in both)
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_a     <= A;
            r_b     <= B;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH = 8). Expected results are
//   pushed to a scoreboard queue when an operation is issued and popped when
//   done pulses; handshake timing and output holding are checked cycle by
//   cycle from the issuing sequence.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] held_d    = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .D    (D),
    .Bout (Bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] diff;
    diff   = {1'b0, a} - {1'b0, b};
    e.d    = diff[W-1:0];
    e.bout = diff[W];
    e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compares every done pulse against the oldest entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_tests++;
      assert (sb.size() > 0)
      else begin
        n_fail++;
        $error("FAIL sb_unexpected_done observed=1 expected=0");
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_D", 32'(D), 32'(e.d));
        check("sb_Bout", 32'(Bout), 32'(e.bout));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
        $display("[TB] done: D=0x%02h Bout=%0d ovf=%0d (exp 0x%02h %0d %0d)",
                 D, Bout, ovf, e.d, e.bout, e.ovf);
      end
    end
  end

  // Issue one operation (start must be legal now) and follow it to done.
  // hold: keep start high and scramble A/B during RUN.
  // b2b : return in the DONE cycle so the caller can chain the next op.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit b2b);
    exp_t e;
    e = model(a, b);
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(e);
    $display("[TB] issue A=0x%02h B=0x%02h hold=%0d b2b=%0d", a, b, hold, b2b);
    clk1();  // accepting edge k
    if (hold) begin
      A = ~a;
      B = a ^ 8'h5A;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("hold_D", 32'(D), 32'(held_d));
      check("hold_Bout", 32'(Bout), 32'(held_bout));
      check("hold_ovf", 32'(ovf), 32'(held_ovf));
      clk1();
    end
    // now just past edge k+W: DONE cycle
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    held_d    = e.d;
    held_bout = e.bout;
    held_ovf  = e.ovf;
    if (!b2b) begin
      start = 1'b0;
      clk1();
      check("after_done", 32'(done), 32'd0);
      check("after_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;  // rst must win over start
    A     = 8'hAA;
    B     = 8'h55;
    clk1();
    clk1();
    start = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    clk1();

    // basic and borrow cases
    run_op(8'd100, 8'd37, 1'b0, 1'b0);
    run_op(8'd37, 8'd100, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    // signed overflow
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);

    // start held with operands scrambled mid-run, then chained op in DONE
    run_op(8'hC3, 8'h3C, 1'b1, 1'b1);
    run_op(8'd5, 8'd3, 1'b0, 1'b1);
    // chained again back-to-back from the DONE cycle
    run_op(8'h12, 8'h34, 1'b0, 1'b0);

    // reset in the 4th RUN cycle
    A     = 8'h33;
    B     = 8'h44;
    start = 1'b1;
    $display("[TB] issue A=0x33 B=0x44 then reset mid-run");
    clk1();
    start = 1'b0;
    clk1();
    clk1();
    clk1();
    rst = 1'b1;
    clk1();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_D", 32'(D), 32'd0);
    check("mid_rst_Bout", 32'(Bout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    rst       = 1'b0;
    held_d    = '0;
    held_bout = 1'b0;
    held_ovf  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clk1();
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_op(8'd200, 8'd55, 1'b0, 1'b0);

    // a few pseudo-random operations
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    clk1();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
